// File: rtl/mem_port_arbiter.sv
// Shared single-port RAM arbiter between instruction fetch and the memory stage.
// Three-state access (IDLE -> ACC -> RESP); the completion pulse appears in the following IDLE cycle.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_abort,
  input  logic        mem_rd_req,
  input  logic        mem_wr_req,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [29:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_w_en,
  input  logic [31:0] ram_rdata,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        mem_rd_valid,
  output logic [31:0] mem_rdata,
  output logic        mem_wr_done,
  output logic        sel_stall,
  output logic        if_stall,
  output logic        protocol_err
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_MRD, OWN_MWR} owner_t;

  typedef struct packed {
    owner_t      owner;
    logic [29:0] waddr;
    logic [31:0] wdata;
  } acc_t;

  state_t      state, state_nxt;
  acc_t        acc_q, acc_nxt;
  logic [1:0]  starve_q, starve_nxt;
  logic        abort_q;
  logic        if_vld_q, rd_vld_q, wr_done_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        elig_if, elig_rd, elig_wr;
  logic        gnt;
  owner_t      gnt_own;

  // Byte-lane bits are ignored; the RAM is word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], mem_addr[1:0]};

  // Pulses are forced low while reset is held so nothing completes across a reset.
  assign if_valid     = if_vld_q & ~if_abort & ~rst;
  assign mem_rd_valid = rd_vld_q & ~rst;
  assign mem_wr_done  = wr_done_q & ~rst;
  assign if_rdata     = rdata_q;
  assign mem_rdata    = rdata_q;
  assign protocol_err = err_q;

  assign sel_stall = (mem_rd_req | mem_wr_req) & ~(mem_rd_valid | mem_wr_done);
  assign if_stall  = if_req & ~if_valid;

  assign ram_addr  = acc_q.waddr;
  assign ram_wdata = acc_q.wdata;
  assign ram_w_en  = (state == ACC) & (acc_q.owner == OWN_MWR) & ~rst;

  // A requester completing this cycle is not re-granted in the same cycle.
  assign elig_if = if_req & ~if_abort & ~if_valid;
  assign elig_rd = mem_rd_req & ~mem_rd_valid;
  assign elig_wr = mem_wr_req & ~mem_wr_done;

  always_comb begin
    gnt     = 1'b0;
    gnt_own = OWN_IF;
    if (elig_if && (!(elig_rd || elig_wr) || starve_q == 2'd3)) begin
      gnt     = 1'b1;
      gnt_own = OWN_IF;
    end else if (elig_wr) begin
      gnt     = 1'b1;
      gnt_own = OWN_MWR;
    end else if (elig_rd) begin
      gnt     = 1'b1;
      gnt_own = OWN_MRD;
    end
  end

  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc_q;
    starve_nxt = starve_q;
    case (state)
      IDLE: begin
        if (!if_req || (gnt && gnt_own == OWN_IF))
          starve_nxt = 2'd0;
        else if (gnt && starve_q != 2'd3)
          starve_nxt = starve_q + 2'd1;
        if (gnt) begin
          state_nxt     = ACC;
          acc_nxt.owner = gnt_own;
          acc_nxt.waddr = (gnt_own == OWN_IF) ? if_addr[31:2] : mem_addr[31:2];
          acc_nxt.wdata = mem_wdata;
        end
      end
      ACC:     state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc_q     <= '0;
      starve_q  <= 2'd0;
      abort_q   <= 1'b0;
      if_vld_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      wr_done_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc_q     <= acc_nxt;
      starve_q  <= starve_nxt;
      err_q     <= err_q | (mem_rd_req & mem_wr_req);
      if_vld_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      wr_done_q <= 1'b0;
      if (state == IDLE)
        abort_q <= 1'b0;
      else if (if_abort && acc_q.owner == OWN_IF)
        abort_q <= 1'b1;
      // Aborted fetches still finish the RAM access; only the pulse is dropped.
      if (state == RESP) begin
        rdata_q   <= ram_rdata;
        if_vld_q  <= (acc_q.owner == OWN_IF) & ~abort_q & ~if_abort;
        rd_vld_q  <= (acc_q.owner == OWN_MRD);
        wr_done_q <= (acc_q.owner == OWN_MWR);
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, all scored against a
// timing-based reference model (grant time + 3 completion, shadow RAM, starvation count).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_abort, mem_rd_req, mem_wr_req;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;
  logic        ram_w_en;
  logic        if_valid, mem_rd_valid, mem_wr_done;
  logic [31:0] if_rdata, mem_rdata;
  logic        sel_stall, if_stall, protocol_err;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_abort(if_abort),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_w_en(ram_w_en), .ram_rdata(ram_rdata),
    .if_valid(if_valid), .if_rdata(if_rdata),
    .mem_rd_valid(mem_rd_valid), .mem_rdata(mem_rdata), .mem_wr_done(mem_wr_done),
    .sel_stall(sel_stall), .if_stall(if_stall), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed(input int i);
    return (i == 4) ? 32'hDEAD_BEEF : (32'h0BAD_0000 + 32'(i) * 32'h0000_0111);
  endfunction

  // Environment RAM: 16 words, registered read
  logic [31:0] ram [16];
  bit ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 16; i++) ram[i] <= seed(i);
      ram_ready <= 1'b1;
    end else if (ram_w_en) begin
      ram[ram_addr[3:0]] <= ram_wdata;
    end
    ram_rdata <= ram[ram_addr[3:0]];
  end

  int total = 0;
  int bad   = 0;
  int n     = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, n);
    end
  endtask

  // Reference model state
  logic [31:0] shadow [16];
  bit          pv;
  int          pc, own, free_at, cnt;
  logic [29:0] pa;
  logic [31:0] pw, pd;
  bit          pab, err_m, rst_prev;

  task automatic model_step();
    bit e_ifv, e_rdv, e_wrd, e_wen, e_if, e_rd, e_wr;
    int g;
    logic [31:0] a;
    e_ifv = 0; e_rdv = 0; e_wrd = 0;
    if (pv && pc == n && !rst) begin
      if (own == 0) e_ifv = !pab && !if_abort;
      if (own == 1) e_rdv = 1;
      if (own == 2) e_wrd = 1;
    end
    e_wen = pv && (n == pc - 2) && own == 2 && !rst;
    chk("if_valid", 32'(if_valid), 32'(e_ifv));
    chk("mem_rd_valid", 32'(mem_rd_valid), 32'(e_rdv));
    chk("mem_wr_done", 32'(mem_wr_done), 32'(e_wrd));
    chk("ram_w_en", 32'(ram_w_en), 32'(e_wen));
    if (pv && n == pc - 2 && !rst) begin
      chk("ram_addr", {2'b00, ram_addr}, {2'b00, pa});
      if (own == 2) chk("ram_wdata", ram_wdata, pw);
    end
    if (e_ifv) chk("if_rdata", if_rdata, pd);
    if (e_rdv) chk("mem_rdata", mem_rdata, pd);
    chk("sel_stall", 32'(sel_stall), 32'((mem_rd_req | mem_wr_req) & ~(e_rdv | e_wrd)));
    chk("if_stall", 32'(if_stall), 32'(if_req & ~e_ifv));
    chk("protocol_err", 32'(protocol_err), 32'(err_m));
    if (rst_prev && !rst) begin
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_mem_rdata", mem_rdata, 32'h0);
    end
    rst_prev = rst;
    if (rst) begin
      pv = 0; free_at = n + 1; cnt = 0; err_m = 0;
      return;
    end
    if (pv && own == 0 && if_abort && (n == pc - 2 || n == pc - 1)) pab = 1;
    if (pv && own == 2 && n == pc - 2) shadow[pa[3:0]] = pw;
    err_m = err_m | (mem_rd_req & mem_wr_req);
    if (n >= free_at) begin
      e_if = if_req && !if_abort && !e_ifv;
      e_rd = mem_rd_req && !e_rdv;
      e_wr = mem_wr_req && !e_wrd;
      g = -1;
      if (e_if && (!(e_rd || e_wr) || cnt == 3)) g = 0;
      else if (e_wr) g = 2;
      else if (e_rd) g = 1;
      if (!if_req || g == 0) cnt = 0;
      else if (g > 0 && cnt < 3) cnt++;
      if (g >= 0) begin
        a = (g == 0) ? if_addr : mem_addr;
        pv = 1; pc = n + 3; free_at = n + 3; own = g;
        pa = a[31:2]; pw = mem_wdata; pab = 0; pd = shadow[pa[3:0]];
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic idle_in();
    if_req = 0; if_abort = 0; mem_rd_req = 0; mem_wr_req = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = seed(i);
    pv = 0; free_at = 0; cnt = 0; err_m = 0; rst_prev = 1; pab = 0;
    own = 0; pc = 0; pa = '0; pw = '0; pd = '0;
    rst = 1; idle_in(); if_addr = 0; mem_addr = 0; mem_wdata = 0;
    @(posedge clk); #1;
    cyc(); cyc();
    rst = 0;
    cyc();

    // Single load of word 4
    mem_rd_req = 1; mem_addr = 32'h10;
    repeat (4) cyc();
    idle_in(); cyc(); cyc();

    // Contention: write vs fetch
    if_req = 1; if_addr = 32'h4; mem_wr_req = 1; mem_addr = 32'h20; mem_wdata = 32'h1234_5678;
    repeat (4) cyc();
    mem_wr_req = 0;
    repeat (3) cyc();
    idle_in(); cyc(); cyc();

    // Starvation: fetch held, memory stage alternates load/store every 3 cycles
    if_req = 1; if_addr = 32'h8;
    for (int i = 0; i < 18; i++) begin
      mem_rd_req = ((i / 3) % 2) == 0;
      mem_wr_req = ((i / 3) % 2) == 1;
      mem_addr   = 32'(4 * (i % 16));
      mem_wdata  = 32'hC0DE_0000 + 32'(i);
      cyc();
    end
    idle_in(); cyc(); cyc();

    // Abort at T+2 of a fetch
    if_req = 1; if_addr = 32'h10;
    cyc(); cyc();
    if_abort = 1; cyc();
    if_abort = 0; cyc();
    idle_in(); cyc(); cyc();

    // Reset during the ACC cycle of a store
    mem_wr_req = 1; mem_addr = 32'h30; mem_wdata = 32'hFFFF_0000;
    cyc();
    rst = 1; mem_wr_req = 0; cyc();
    rst = 0; repeat (4) cyc();

    // Protocol error is sticky until reset
    mem_rd_req = 1; mem_wr_req = 1; mem_addr = 32'h0; mem_wdata = 32'h5555_AAAA;
    cyc();
    idle_in(); repeat (6) cyc();
    rst = 1; cyc();
    rst = 0; cyc();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rst        = ($urandom_range(0, 99) < 2);
      if_req     = ($urandom_range(0, 99) < 70);
      if_abort   = ($urandom_range(0, 99) < 10);
      mem_rd_req = ($urandom_range(0, 99) < 35);
      mem_wr_req = ($urandom_range(0, 99) < 25);
      if_addr    = $urandom_range(0, 63);
      mem_addr   = $urandom_range(0, 63);
      mem_wdata  = $urandom;
      cyc();
    end
    rst = 0; idle_in(); repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have ports clk (in, 1) and rst (in, 1); one clock; reset is synchronous and active-high.
REQ-002 SHALL have if_req (in, 1): fetch stage requests an instruction word; level, held until served.
REQ-003 SHALL have if_addr (in, 32): fetch byte address.
REQ-004 SHALL have if_abort (in, 1): taken branch; kills any pending or in-flight fetch.
REQ-005 SHALL have mem_rd_req and mem_wr_req (in, 1 each): memory-stage LDR and STR requests; level, held until served.
REQ-006 SHALL have mem_addr (in, 32) and mem_wdata (in, 32): memory-stage byte address and store data.
REQ-007 SHALL have ram_addr (out, 30), ram_wdata (out, 32), ram_w_en (out, 1) and ram_rdata (in, 32): single-port RAM with a 1-cycle registered read.
REQ-008 SHALL have if_valid (out, 1) and if_rdata (out, 32): fetch completion pulse and instruction word.
REQ-009 SHALL have mem_rd_valid (out, 1), mem_rdata (out, 32) and mem_wr_done (out, 1): load and store completion pulses, plus load data.
REQ-010 SHALL have sel_stall (out, 1) and if_stall (out, 1): pipeline hold requests for the memory and fetch stages.
REQ-011 SHALL have protocol_err (out, 1): sticky flag, set when mem_rd_req and mem_wr_req are high in the same cycle.

Function
REQ-012 SHALL implement the FSM states IDLE, ACC and RESP; only IDLE arbitrates.
REQ-013 Grant in IDLE (cycle T), at the clock edge:
- latch owner (IF, MRD or MWR), address and write data;
- go to ACC.
- If there is no eligible request, stay in IDLE.
REQ-014 ACC (T+1):
- ram_addr = addr_q[31:2]; low two address bits are ignored.
- ram_w_en = 1 only when owner = MWR; ram_wdata = wdata_q.
- Next state is RESP.
REQ-015 RESP (T+2):
- ram_rdata is captured into a data register at the edge.
- Next state is IDLE.
REQ-016 Completion (T+3): exactly one of if_valid, mem_rd_valid or mem_wr_done pulses high for 1 cycle, per the owner.
- if_rdata and mem_rdata hold the captured word until the next capture.
- if_rdata and mem_rdata reset to 0.
REQ-017 Throughput SHALL be at most one access per 3 cycles; request-to-completion latency SHALL be 3 cycles when the port is uncontended.
REQ-018 Priority: a memory-stage request beats fetch, except when the starvation rule applies (REQ-019).
- If mem_rd_req and mem_wr_req are both high, the write wins and protocol_err is set.
REQ-019 Starvation counter (2 bits):
- increments on each memory-stage grant made while if_req is high;
- at value 3, the next IDLE arbitration with if_req high grants fetch;
- clears on any fetch grant, and whenever if_req is low in IDLE.
REQ-020 A requester whose completion pulse is high in the current cycle SHALL NOT be eligible for a grant in that cycle.
REQ-021 if_abort handling:
- if_abort in IDLE makes fetch ineligible that cycle.
- if_abort while owner = IF (in ACC or RESP, or in the completion cycle itself) suppresses if_valid; the RAM access still completes.
REQ-022 Stall outputs are combinational:
- sel_stall = (mem_rd_req | mem_wr_req) & ~(mem_rd_valid | mem_wr_done).
- if_stall = if_req & ~if_valid.
REQ-023 Requests dropped while their access is in flight SHALL NOT abort it; the completion pulse is still issued.

Reset
REQ-024 Reset SHALL apply as follows while rst is high:
- state = IDLE;
- counter = 0;
- protocol_err = 0;
- all valid and done pulses = 0;
- data registers = 0;
- ram_w_en = 0 even in a cycle when the state is ACC.
REQ-025 Reset mid-access SHALL discard the access; no completion pulse SHALL follow the reset.

Verification
REQ-026 Single load: mem_rd_req=1, mem_addr=0x0000_0010, RAM word[4]=0xDEAD_BEEF.
- Required: ram_addr=4 at T+1; mem_rd_valid=1 and mem_rdata=0xDEAD_BEEF at T+3.
- Required: sel_stall=1 during T..T+2 and 0 at T+3.
REQ-027 Contention: if_req and mem_wr_req both high at T, mem_addr=0x20, mem_wdata=0x1234_5678.
- Required: ram_w_en=1 with ram_addr=8 at T+1; mem_wr_done at T+3.
- Required: fetch granted at T+3 (the write requester is excluded, REQ-020); if_valid at T+6.
REQ-028 Starvation: if_req held high, memory-stage requests back-to-back.
- Required: three memory grants, then a fetch grant; the fourth memory access starts only after if_valid.
REQ-029 Abort: fetch granted at T, if_abort=1 at T+2.
- Required: if_valid stays 0 at T+3; the state is IDLE at T+3.
REQ-030 Reset/error checks:
- rst asserted during an ACC write: ram_w_en=0 in that cycle; no mem_wr_done; state IDLE next cycle.
- mem_rd_req and mem_wr_req both high: protocol_err=1 and it stays 1 until rst.
